// File: rtl/serial_adder_pkg.sv
// Shared state encoding and parameter legality check for the digit-serial adder.
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic bit params_legal(input int width, input int digit);
        return (digit >= 1) && (width >= 2) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit adder with carry in/out; one slice of the serial sum.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle conditional adder: z = add_en ? m + n + cin : m, DIGIT bits per clock, LSD first.
// Add takes N cycles to done, bypass goes straight to DONE; start is ignored while busy.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] n,
    input  logic             add_en,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    generate
        if (!params_legal(WIDTH, DIGIT)) begin : g_bad_params
            $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] m_q, m_d, n_q, n_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             accept;
    logic [DIGIT-1:0] dig_s;
    logic             dig_co;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a  (m_q[idx_q*DIGIT +: DIGIT]),
        .b  (n_q[idx_q*DIGIT +: DIGIT]),
        .ci (carry_q),
        .s  (dig_s),
        .co (dig_co)
    );

    assign accept = start && (state_q != ST_RUN);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        m_d     = m_q;
        n_d     = n_q;
        work_d  = work_q;
        z_d     = z_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_RUN: begin
                work_d[idx_q*DIGIT +: DIGIT] = dig_s;
                carry_d = dig_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Result only becomes visible here, so z never shows partial sums.
                    state_d = ST_DONE;
                    z_d     = work_d;
                    cout_d  = dig_co;
                    ovf_d   = (m_q[WIDTH-1] == n_q[WIDTH-1]) &&
                              (dig_s[DIGIT-1] != m_q[WIDTH-1]);
                end
            end
            default: begin
                if (accept) begin
                    m_d     = m;
                    n_d     = n;
                    idx_d   = '0;
                    carry_d = cin;
                    if (add_en) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                        z_d     = m;
                        cout_d  = 1'b0;
                        ovf_d   = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            m_q     <= '0;
            n_q     <= '0;
            work_q  <= '0;
            z_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            m_q     <= m_d;
            n_q     <= n_d;
            work_q  <= work_d;
            z_q     <= z_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready = (state_q != ST_RUN);
    assign done  = (state_q == ST_DONE);
    assign z     = z_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=16, DIGIT=4.
module tb_serial_adder;

    localparam int W = 16;
    localparam int D = 4;
    localparam int N = W / D;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] m;
    logic [W-1:0] n;
    logic         add_en;
    logic         cin;
    logic         ready;
    logic         done;
    logic [W-1:0] z;
    logic         cout;
    logic         ovf;

    typedef struct packed {
        logic [W-1:0] z;
        logic         cout;
        logic         ovf;
    } res_t;

    res_t sb_q[$];
    res_t exp_r;
    int   checks   = 0;
    int   failures = 0;

    serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .m      (m),
        .n      (n),
        .add_en (add_en),
        .cin    (cin),
        .ready  (ready),
        .done   (done),
        .z      (z),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic ae);
        logic [W:0] s;
        res_t       r;
        if (!ae) begin
            r.z    = a;
            r.cout = 1'b0;
            r.ovf  = 1'b0;
        end else begin
            s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            r.z    = s[W-1:0];
            r.cout = s[W];
            r.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end
        return r;
    endfunction

    // Result monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_r = sb_q.pop_front();
                chk("res_z", 32'(z), 32'(exp_r.z));
                chk("res_cout", 32'(cout), 32'(exp_r.cout));
                chk("res_ovf", 32'(ovf), 32'(exp_r.ovf));
            end
        end
    end

    // Launch one operation from a negedge, scramble inputs while busy, measure latency.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic ae, input int exp_lat, input string tag);
        int lat;
        int waitc;
        bit busy_ok;
        waitc = 0;
        while (ready !== 1'b1 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 100) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
        m = a; n = b; cin = ci; add_en = ae; start = 1'b1;
        sb_q.push_back(model(a, b, ci, ae));
        @(negedge clk);
        start   = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 100) begin
            if (ready !== 1'b0) busy_ok = 1'b0;
            m   = W'($urandom);
            n   = W'($urandom);
            cin = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (ae) chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
    endtask

    initial begin
        int  k;
        bit  held;
        rst = 1'b1; start = 1'b0; m = '0; n = '0; add_en = 1'b0; cin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_z", 32'(z), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        do_op(16'h00FF, 16'h0001, 1'b0, 1'b1, N, "t1_basic");
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, N, "t2_wrap");
        do_op(16'h7FFF, 16'h0000, 1'b1, 1'b1, N, "t2_ovf");
        do_op(16'h8000, 16'h8000, 1'b0, 1'b1, N, "t2_negovf");
        do_op(16'h1234, 16'hFFFF, 1'b1, 1'b0, 0, "t3_bypass");

        // Bypass held back-to-back: one result per cycle.
        @(negedge clk);
        add_en = 1'b0; cin = 1'b1; n = 16'hFFFF; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m = 16'(16'hA000 + i);
            sb_q.push_back(model(m, n, cin, add_en));
            @(negedge clk);
            chk("t3_thru_done", 32'(done), 32'd1);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Busy start ignored, then start held into DONE for a back-to-back add.
        m = 16'h1111; n = 16'h2222; cin = 1'b0; add_en = 1'b1; start = 1'b1;
        sb_q.push_back(model(16'h1111, 16'h2222, 1'b0, 1'b1));
        @(negedge clk);
        m = 16'hAAAA; n = 16'h5555; cin = 1'b1;
        @(negedge clk);
        m = 16'h0003; n = 16'h0004; cin = 1'b0;
        sb_q.push_back(model(16'h0003, 16'h0004, 1'b0, 1'b1));
        k = 1;
        while (done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t4_first_lat", 32'(k), 32'(N));
        @(negedge clk);
        start = 1'b0;
        k     = 0;
        held  = 1'b1;
        while (done !== 1'b1 && k < 100) begin
            if (z !== 16'h3333) held = 1'b0;
            @(negedge clk);
            k++;
        end
        chk("t4_second_lat", 32'(k), 32'(N));
        chk("t4_z_held", 32'(held), 32'd1);

        // Reset after two RUN cycles with a carry pending.
        @(negedge clk);
        m = 16'h00FF; n = 16'h0001; cin = 1'b1; add_en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_ready", 32'(ready), 32'd1);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_z", 32'(z), 32'd0);
        chk("t5_cout", 32'(cout), 32'd0);
        chk("t5_ovf", 32'(ovf), 32'd0);
        do_op(16'h0010, 16'h0020, 1'b0, 1'b1, N, "t5_after");

        for (int i = 0; i < 6; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, N, "t6_rand");
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
